// File: rtl/lcd_timing_pkg.sv
// Shared constants for the LCD timing generator: default panel timing,
// RGB565 colour-bar palette and the bar count used by the test pattern.
package lcd_timing_pkg;

    // Default timing for a 480x272 panel
    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 8;
    localparam int DEF_H_SYNC   = 4;
    localparam int DEF_H_BP     = 43;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 8;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BP     = 12;

    // Largest total that still fits the 11-bit counters and X/Y outputs
    localparam int MAX_TOTAL    = 2047;

    // Number of vertical colour bars across the active width
    localparam int BAR_COUNT    = 8;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_t;

    localparam rgb565_t RGB_WHITE   = 16'hFFFF;
    localparam rgb565_t RGB_YELLOW  = 16'hFFE0;
    localparam rgb565_t RGB_CYAN    = 16'h07FF;
    localparam rgb565_t RGB_GREEN   = 16'h07E0;
    localparam rgb565_t RGB_MAGENTA = 16'hF81F;
    localparam rgb565_t RGB_RED     = 16'hF800;
    localparam rgb565_t RGB_BLUE    = 16'h001F;
    localparam rgb565_t RGB_BLACK   = 16'h0000;

    // Map a bar index (0 = leftmost) to its colour
    function automatic rgb565_t bar_color(input logic [2:0] idx);
        rgb565_t c;
        c = RGB_BLACK;
        case (bar_t'(idx))
            BAR_WHITE:   c = RGB_WHITE;
            BAR_YELLOW:  c = RGB_YELLOW;
            BAR_CYAN:    c = RGB_CYAN;
            BAR_GREEN:   c = RGB_GREEN;
            BAR_MAGENTA: c = RGB_MAGENTA;
            BAR_RED:     c = RGB_RED;
            BAR_BLUE:    c = RGB_BLUE;
            BAR_BLACK:   c = RGB_BLACK;
            default:     c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One timing axis counter: counts 0..TOTAL-1 on enabled steps and raises
// carry combinationally on the step that wraps it back to zero.
module lcd_axis_cnt #(
    parameter int TOTAL = 535,
    parameter int WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             step,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TOTAL - 1);

    assign carry = ce && step && (count == LAST);

    // Advance on a CE-qualified step, wrapping at TOTAL-1
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (ce && step) begin
            count <= carry ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// LCD raster timing generator: H/V counters, registered DEN/X/Y, active-low
// syncs and line/frame start pulses, all one CE-cycle behind the counters.
// Optional colour-bar test pattern is built when LCD_TIMING_TEST_PATTERN_EN
// is defined; otherwise TP_R/G/B are tied to zero.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic        CLK,
    input  logic        RST_IN,
    input  logic        CE,
    output logic        DEN,
    output logic [10:0] X,
    output logic [10:0] Y,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        LINE_START,
    output logic        FRAME_START,
    output logic [4:0]  TP_R,
    output logic [5:0]  TP_G,
    output logic [4:0]  TP_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > MAX_TOTAL) begin : g_h_total_chk
        $error("lcd_timing_gen: H_TOTAL exceeds 2047");
    end
    if (V_TOTAL > MAX_TOTAL) begin : g_v_total_chk
        $error("lcd_timing_gen: V_TOTAL exceeds 2047");
    end

    logic [10:0] hcnt;
    logic [10:0] vcnt;
    logic        h_carry;

    lcd_axis_cnt #(.TOTAL(H_TOTAL), .WIDTH(11)) u_hcnt (
        .clk   (CLK),
        .rst   (RST_IN),
        .ce    (CE),
        .step  (1'b1),
        .count (hcnt),
        .carry (h_carry)
    );

    lcd_axis_cnt #(.TOTAL(V_TOTAL), .WIDTH(11)) u_vcnt (
        .clk   (CLK),
        .rst   (RST_IN),
        .ce    (CE),
        .step  (h_carry),
        .count (vcnt),
        .carry ()
    );

    logic h_act;
    logic v_act;
    logic den_now;
    logic hs_on;
    logic vs_on;

    assign h_act   = hcnt < H_ACT;
    assign v_act   = vcnt < V_ACT;
    assign den_now = h_act && v_act;
    assign hs_on   = (hcnt >= HS_BEG) && (hcnt < HS_END);
    assign vs_on   = (vcnt >= VS_BEG) && (vcnt < VS_END);

    // Register the raster outputs from the current counter values; pulses self-clear
    always_ff @(posedge CLK) begin
        if (RST_IN) begin
            DEN         <= 1'b0;
            X           <= '0;
            Y           <= '0;
            HSYNC       <= 1'b1;
            VSYNC       <= 1'b1;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
            if (CE) begin
                DEN         <= den_now;
                X           <= den_now ? hcnt : '0;
                Y           <= den_now ? vcnt : '0;
                HSYNC       <= ~hs_on;
                VSYNC       <= ~vs_on;
                LINE_START  <= (hcnt == '0) && v_act;
                FRAME_START <= (hcnt == '0) && (vcnt == '0);
            end
        end
    end

`ifdef LCD_TIMING_TEST_PATTERN_EN
    localparam int          BAR_W    = H_ACTIVE / BAR_COUNT;
    localparam logic [10:0] BAR_LAST = 11'(BAR_W - 1);
    localparam logic [2:0]  BAR_MAX  = 3'(BAR_COUNT - 1);

    logic [10:0] bar_pix;
    logic [2:0]  bar_idx;
    rgb565_t     tp;

    // Track the bar under hcnt with a pixel counter restarted at each line start
    always_ff @(posedge CLK) begin
        if (RST_IN) begin
            bar_pix <= '0;
            bar_idx <= '0;
        end else if (CE) begin
            if (h_carry) begin
                bar_pix <= '0;
                bar_idx <= '0;
            end else if (bar_pix == BAR_LAST) begin
                bar_pix <= '0;
                if (bar_idx != BAR_MAX) begin
                    bar_idx <= bar_idx + 1'b1;
                end
            end else begin
                bar_pix <= bar_pix + 1'b1;
            end
        end
    end

    // Register the bar colour inside the active area, black in blanking
    always_ff @(posedge CLK) begin
        if (RST_IN) begin
            tp <= '0;
        end else if (CE) begin
            tp <= den_now ? bar_color(bar_idx) : '0;
        end
    end

    assign TP_R = tp.r;
    assign TP_G = tp.g;
    assign TP_B = tp.b;
`else
    assign TP_R = '0;
    assign TP_G = '0;
    assign TP_B = '0;
`endif

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Self-checking bench for lcd_timing_gen using a reduced raster so whole
// frames fit in a short run. Expected outputs come from an arithmetic model
// that maps the number of CE edges since reset to a raster position.
module tb_lcd_timing_gen;

    localparam int HA  = 48;
    localparam int HFP = 4;
    localparam int HS  = 3;
    localparam int HBP = 5;
    localparam int VA  = 10;
    localparam int VFP = 2;
    localparam int VS  = 2;
    localparam int VBP = 3;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int BW  = HA / 8;

    logic        clk = 1'b0;
    logic        RST_IN;
    logic        CE;
    logic        DEN;
    logic [10:0] X;
    logic [10:0] Y;
    logic        HSYNC;
    logic        VSYNC;
    logic        LINE_START;
    logic        FRAME_START;
    logic [4:0]  TP_R;
    logic [5:0]  TP_G;
    logic [4:0]  TP_B;

    int checks = 0;
    int errors = 0;
    int pos    = 0;
    logic [42:0] expv;
    logic [42:0] act;
    logic [15:0] colors [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    lcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .CLK(clk), .RST_IN(RST_IN), .CE(CE),
        .DEN(DEN), .X(X), .Y(Y), .HSYNC(HSYNC), .VSYNC(VSYNC),
        .LINE_START(LINE_START), .FRAME_START(FRAME_START),
        .TP_R(TP_R), .TP_G(TP_G), .TP_B(TP_B)
    );

    always #5 clk = ~clk;

    assign act = {DEN, X, Y, HSYNC, VSYNC, LINE_START, FRAME_START, TP_R, TP_G, TP_B};

    // Expected output vector for the raster position reached after p CE edges
    function automatic logic [42:0] ref_out(input int p);
        int h;
        int v;
        logic den;
        logic [15:0] tp;
        h   = p % HT;
        v   = (p / HT) % VT;
        den = (h < HA) && (v < VA);
        tp  = 16'h0;
`ifdef LCD_TIMING_TEST_PATTERN_EN
        if (den) tp = colors[(h / BW) > 7 ? 7 : (h / BW)];
`endif
        return {den, den ? 11'(h) : 11'd0, den ? 11'(v) : 11'd0,
                !((h >= HA + HFP) && (h < HA + HFP + HS)),
                !((v >= VA + VFP) && (v < VA + VFP + VS)),
                (h == 0) && (v < VA), (h == 0) && (v == 0), tp};
    endfunction

    // One clock with the given reset/enable, updating the model expectation
    task automatic applyStimulus(input logic r, input logic c);
        RST_IN = r;
        CE     = c;
        @(posedge clk);
        #1;
        if (r) begin
            expv = {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0};
            pos  = 0;
        end else if (c) begin
            expv = ref_out(pos);
            pos++;
        end else begin
            expv[17:16] = 2'b00;
        end
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL reset_state got %h want %h", act, expv);
        end
        checks++;
        if (HSYNC !== 1'b1 || VSYNC !== 1'b1 || DEN !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_syncs got hs=%b vs=%b den=%b want 1 1 0", HSYNC, VSYNC, DEN);
        end
    endtask

    task automatic test_release();
        for (int i = 1; i <= FRAME; i++) begin
            applyStimulus(1'b0, 1'b1);
            checks++;
            if (act !== expv) begin
                errors++;
                $display("[TB] FAIL release_model edge %0d got %h want %h", i, act, expv);
            end
            if (i == 1) begin
                checks++;
                if ({FRAME_START, DEN, X, Y} !== {1'b1, 1'b1, 11'd0, 11'd0}) begin
                    errors++;
                    $display("[TB] FAIL release_first got fs=%b den=%b x=%0d y=%0d want 1 1 0 0",
                             FRAME_START, DEN, X, Y);
                end
            end
            if (i == HA) begin
                checks++;
                if (X !== 11'(HA - 1)) begin
                    errors++;
                    $display("[TB] FAIL release_last_x got %0d want %0d", X, HA - 1);
                end
            end
            if (i == HA + 1) begin
                checks++;
                if (DEN !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL release_den_off got %b want 0", DEN);
                end
            end
        end
    endtask

    task automatic test_sync_windows();
        int hs_line0;
        int hs_first;
        int hs_total;
        int vs_total;
        hs_line0 = 0;
        hs_first = -1;
        hs_total = 0;
        vs_total = 0;
        for (int i = 0; i < FRAME; i++) begin
            applyStimulus(1'b0, 1'b1);
            if (HSYNC === 1'b0) begin
                hs_total++;
                if (i < HT) begin
                    hs_line0++;
                    if (hs_first < 0) hs_first = i;
                end
            end
            if (VSYNC === 1'b0) vs_total++;
        end
        checks++;
        if (hs_line0 != HS || hs_first != HA + HFP) begin
            errors++;
            $display("[TB] FAIL hsync_window got len=%0d start=%0d want %0d %0d",
                     hs_line0, hs_first, HS, HA + HFP);
        end
        checks++;
        if (hs_total != HS * VT) begin
            errors++;
            $display("[TB] FAIL hsync_frame got %0d want %0d", hs_total, HS * VT);
        end
        checks++;
        if (vs_total != VS * HT) begin
            errors++;
            $display("[TB] FAIL vsync_window got %0d want %0d", vs_total, VS * HT);
        end
    endtask

    task automatic test_frame_wrap();
        int last_fs;
        int lines;
        int frames;
        last_fs = -1;
        lines   = 0;
        frames  = 0;
        for (int i = 0; i < 2 * FRAME + 1; i++) begin
            applyStimulus(1'b0, 1'b1);
            checks++;
            if (act !== expv) begin
                errors++;
                $display("[TB] FAIL wrap_model cycle %0d got %h want %h", i, act, expv);
            end
            if (FRAME_START === 1'b1) begin
                if (last_fs >= 0) begin
                    frames++;
                    checks++;
                    if (i - last_fs != FRAME || lines != VA) begin
                        errors++;
                        $display("[TB] FAIL frame_period got %0d lines %0d want %0d lines %0d",
                                 i - last_fs, lines, FRAME, VA);
                    end
                end
                last_fs = i;
                lines   = 0;
            end
            if (LINE_START === 1'b1) lines++;
        end
        checks++;
        if (frames != 2) begin
            errors++;
            $display("[TB] FAIL frame_count got %0d want 2", frames);
        end
    endtask

    task automatic test_ce_toggle();
        logic prev_ls;
        logic prev_fs;
        prev_ls = 1'b0;
        prev_fs = 1'b0;
        for (int i = 0; i < 4 * HT; i++) begin
            applyStimulus(1'b0, (i % 2) == 0);
            checks++;
            if (act !== expv || (prev_ls && LINE_START) || (prev_fs && FRAME_START)) begin
                errors++;
                $display("[TB] FAIL ce_alternate cycle %0d got %h want %h", i, act, expv);
            end
            prev_ls = LINE_START;
            prev_fs = FRAME_START;
        end
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(1'b0, $urandom_range(0, 3) != 0);
            checks++;
            if (act !== expv) begin
                errors++;
                $display("[TB] FAIL ce_random cycle %0d got %h want %h", i, act, expv);
            end
        end
    endtask

    task automatic test_mid_reset();
        int target;
        int n;
        target = 8 * HT + 20;
        n = 0;
        while ((pos % FRAME) != target && n < 2 * FRAME) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        checks++;
        if ((pos % FRAME) != target || act !== expv) begin
            errors++;
            $display("[TB] FAIL midreset_reach got %h want %h", act, expv);
        end
        applyStimulus(1'b1, 1'b1);
        checks++;
        if (act !== {1'b0, 11'd0, 11'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0}) begin
            errors++;
            $display("[TB] FAIL midreset_state got %h want %h", act, expv);
        end
        applyStimulus(1'b0, 1'b1);
        checks++;
        if ({FRAME_START, LINE_START, DEN, X, Y} !== {1'b1, 1'b1, 1'b1, 11'd0, 11'd0}) begin
            errors++;
            $display("[TB] FAIL midreset_restart got fs=%b ls=%b den=%b x=%0d y=%0d want 1 1 1 0 0",
                     FRAME_START, LINE_START, DEN, X, Y);
        end
    endtask

    task automatic checkOutput();
        int h;
        logic [15:0] want;
        logic [15:0] got;
        for (int i = 1; i < HT; i++) begin
            applyStimulus(1'b0, 1'b1);
            h    = (pos - 1) % HT;
            got  = {TP_R, TP_G, TP_B};
            want = 16'h0;
`ifdef LCD_TIMING_TEST_PATTERN_EN
            if (h < BW) want = 16'hFFFF;
            else if (h >= BW && h < 2 * BW) want = 16'hFFE0;
            else if (h >= 2 * BW && h < 7 * BW) want = colors[h / BW];
`endif
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL pattern x=%0d got %h want %h", h, got, want);
            end
        end
    endtask

    initial begin
        RST_IN = 1'b1;
        CE     = 1'b0;
        expv   = '0;
        test_reset();
        test_release();
        test_sync_windows();
        test_frame_wrap();
        test_ce_toggle();
        test_mid_reset();
        checkOutput();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, visible pixels per line.
REQ-002 SHALL have parameters H_FP 8, H_SYNC 4, H_BP 43, giving the horizontal front porch, sync and back porch in pixels.
REQ-003 SHALL have parameters V_ACTIVE 272, V_FP 8, V_SYNC 4, V_BP 12, giving the vertical timing in lines.
REQ-004 SHALL have port CLK, input, 1 bit: the single clock.
REQ-005 SHALL have port RST_IN, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port CE, input, 1 bit: pixel-clock enable.
REQ-007 SHALL have port DEN, output, 1 bit: data enable, high inside the active area.
REQ-008 SHALL have port X, output, 11 bits: active pixel column.
REQ-009 SHALL have port Y, output, 11 bits: active pixel row.
REQ-010 SHALL have ports HSYNC and VSYNC, output, 1 bit each: active-low syncs.
REQ-011 SHALL have ports LINE_START and FRAME_START, output, 1 bit each: single-CLK pulses.
REQ-012 SHALL have ports TP_R (5 bits), TP_G (6 bits) and TP_B (5 bits), outputs: test-pattern colour.

Function
REQ-013 SHALL keep the internal counter hcnt in the range 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 535).
REQ-014 SHALL keep the internal counter vcnt in the range 0..V_TOTAL-1 (default 296).
REQ-015 SHALL advance the counters only on a CLK edge with CE=1; with CE=0, counters and all outputs hold, except that pulses clear.
REQ-016 SHALL order the line as active [0, H_ACTIVE), then FP, then SYNC, then BP; vertical ordering SHALL be identical, measured in lines.
REQ-017 SHALL wrap hcnt to 0 when hcnt=H_TOTAL-1 and CE=1.
REQ-018 SHALL increment vcnt on that same edge, and wrap vcnt to 0 if vcnt=V_TOTAL-1.
REQ-019 SHALL register all outputs, with latency one CE-qualified cycle: outputs at edge k+1 reflect the counter values at edge k.
REQ-020 SHALL drive DEN=1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-021 SHALL drive X=hcnt and Y=vcnt while DEN=1, and drive X=0 and Y=0 while DEN=0.
REQ-022 SHALL drive HSYNC=0 iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, and drive VSYNC low over the equivalent vertical window for whole lines.
REQ-023 SHALL pulse LINE_START for exactly one CLK cycle when the outputs first reflect hcnt=0 with vcnt<V_ACTIVE.
REQ-024 SHALL pulse FRAME_START for exactly one CLK cycle when the outputs first reflect hcnt=0 and vcnt=0; it SHALL coincide with LINE_START.
REQ-025 SHALL emit no duplicate pulses when CE stays low after a pulse.
REQ-026 SHALL restart any frame in progress at hcnt=0 and vcnt=0 when RST_IN is asserted mid-frame, with no partial pulses.

Reset
REQ-027 SHALL, on RST_IN=1 at a CLK edge, clear hcnt, vcnt, DEN, X, Y, LINE_START, FRAME_START and TP_R/G/B to 0.
REQ-028 SHALL set HSYNC and VSYNC to 1 (inactive) during reset.
REQ-029 SHALL, on the first CE=1 edge after reset release, drive DEN=1, X=0, Y=0 and FRAME_START=1.

Configuration
REQ-030 SHALL, with macro LCD_TIMING_TEST_PATTERN_EN defined, drive TP_R/G/B with eight vertical colour bars while DEN=1: white, yellow, cyan, green, magenta, red, blue, black.
REQ-031 SHALL make each bar BAR_W = H_ACTIVE/8 pixels wide (60 by default), using a bar counter reset at each line start rather than a divider.
REQ-032 SHALL saturate the bar index at 7, and drive TP=0 while DEN=0.
REQ-033 SHALL, with LCD_TIMING_TEST_PATTERN_EN undefined, tie TP_R/G/B to 0 and omit the bar logic.

Structure
REQ-034 SHALL place the default timing constants, the RGB565 bar-colour constants and the bar-count constant (8) in the shared package lcd_timing_pkg.
REQ-035 SHALL implement each axis counter (wrap at TOTAL-1, carry out, CE-qualified) as sub-module lcd_axis_cnt, instantiated once for H and once for V.
REQ-036 SHALL check at elaboration that H_TOTAL and V_TOTAL are at most 2047.

Verification
REQ-037 SHALL cover reset release with CE=1: FRAME_START=1, DEN=1, X=0 and Y=0 on the first edge; X=479 on edge 480; DEN=0 on edge 481.
REQ-038 SHALL cover sync windows with defaults: HSYNC low for exactly 4 cycles, hcnt 488..491; VSYNC low for exactly 4×535 cycles, vcnt 280..283.
REQ-039 SHALL cover frame wrap: FRAME_START pulses exactly every 535×296=158360 CE cycles, and LINE_START pulses 272 times per frame.
REQ-040 SHALL cover CE toggling 1/0 alternately: identical output sequence at half rate, with every pulse exactly one CLK wide.
REQ-041 SHALL cover RST_IN asserted at vcnt=150, hcnt=200: syncs return high and the next frame starts at X=0, Y=0 with FRAME_START.
REQ-042 SHALL cover the test pattern with the macro on: TP=16'hFFFF at X=0..59, yellow from X=60, black at X=420..479, and TP=0 in blanking.
